// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: load/store sequencer that sits in front of a byte-wide data
// memory. Each word/halfword/byte request is split into one byte access per
// cycle at consecutive (wrapping) addresses. Load bytes are assembled
// little-endian and then sign- or zero-extended to 32 bits.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake (accept when both high in IDLE)
//   req_we          1 = store, 0 = load
//   req_addr        byte address of the lowest byte
//   req_wdata       store data, low N bytes used
//   req_type        000 W, 001 H, 010 HU, 011 B, 100 BU, 101-111 illegal
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data (0 for stores and errors)
//   resp_err        illegal req_type, qualified by resp_valid
//   mem_en/we/addr/wdata  byte memory access for the current cycle
//   mem_rdata       read byte, valid the cycle after its address
module lsu_byte_seq #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_type,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched request
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [2:0]        op_type;

  logic [1:0]  cnt, cnt_next;     // byte index currently being issued
  logic [1:0]  prev_idx;          // byte whose read data arrives this cycle
  logic [1:0]  last_idx;          // N-1 for the latched type
  logic [31:0] asm_q, asm_next;   // load assembly register
  logic        req_legal;
  logic        resp_load;
  logic [31:0] resp_rdata_next;
  logic        resp_err_next;

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [2:0] t);
    case (t)
      3'b000:  return a;
      3'b001:  return {{16{a[15]}}, a[15:0]};
      3'b010:  return {16'h0000, a[15:0]};
      3'b011:  return {{24{a[7]}}, a[7:0]};
      default: return {24'h000000, a[7:0]};
    endcase
  endfunction

  assign req_legal = (req_type <= 3'd4);
  assign prev_idx  = cnt - 2'd1;

  always_comb begin
    case (op_type)
      3'b000:         last_idx = 2'd3;
      3'b001, 3'b010: last_idx = 2'd1;
      default:        last_idx = 2'd0;
    endcase
  end

  // NOTE: combinational block uses blocking assignments and gives every
  // output a default first, so no path can leave a latch behind.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    asm_next        = asm_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = 8'h00;
    resp_load       = 1'b0;
    resp_rdata_next = 32'h0;
    resp_err_next   = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_next = 2'd0;
          asm_next = 32'h0;
          if (req_legal) begin
            state_next = ISSUE;
          end else begin
            // Illegal type: answer next cycle without touching memory.
            state_next    = RESP;
            resp_load     = 1'b1;
            resp_err_next = 1'b1;
          end
        end
      end

      ISSUE: begin
        mem_en   = 1'b1;
        mem_we   = op_we;
        mem_addr = op_addr + ADDR_W'(cnt);  // wraps modulo memory size
        if (op_we) begin
          mem_wdata = op_wdata[{cnt, 3'b000} +: 8];
        end else if (cnt != 2'd0) begin
          // Read data for the byte issued last cycle is on mem_rdata now.
          asm_next[{prev_idx, 3'b000} +: 8] = mem_rdata;
        end
        if (cnt == last_idx) begin
          if (op_we) begin
            state_next = RESP;
            resp_load  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          cnt_next = cnt + 2'd1;
        end
      end

      DRAIN: begin
        // Final load byte arrives one cycle after the last issue.
        asm_next[{cnt, 3'b000} +: 8] = mem_rdata;
        state_next      = RESP;
        resp_load       = 1'b1;
        resp_rdata_next = extend(asm_next, op_type);
      end

      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      asm_q      <= 32'h0;
      op_we      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= 32'h0;
      op_type    <= 3'b000;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      asm_q <= asm_next;
      if (req_ready && req_valid) begin
        op_we    <= req_we;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
        op_type  <= req_type;
      end
      // Response fields hold between responses.
      if (resp_load) begin
        resp_rdata <= resp_rdata_next;
        resp_err   <= resp_err_next;
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
module tb_lsu_byte_seq;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_type;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_err    = 0;
  int resp_count = 0;

  logic [7:0] mem    [DEPTH];   // memory attached to the DUT
  logic [7:0] shadow [DEPTH];   // reference model's view of memory
  logic       mem_init;

  lsu_byte_seq #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 19) & 255);
  endfunction

  // Registered-read byte memory
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_byte(i);
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) if (resp_valid) resp_count++;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] t);
    case (t)
      3'b000:         return 4;
      3'b001, 3'b010: return 2;
      3'b011, 3'b100: return 1;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [2:0] t);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(t); i++)
      v = v | (32'(shadow[(a + i) % DEPTH]) << (8 * i));
    if (t == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF0000;
    if (t == 3'b011 && v >= 32'h80)   v = v + 32'hFFFFFF00;
    return v;
  endfunction

  function automatic void apply_store(input int a, input logic [31:0] wd, input logic [2:0] t);
    for (int i = 0; i < nbytes(t); i++)
      shadow[(a + i) % DEPTH] = wd[8*i +: 8];
  endfunction

  // One complete request. Called and returns at a falling edge, so a
  // following call is accepted on the first IDLE cycle after RESP.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [2:0] typ, output logic [31:0] rd, output logic er);
    int n, last;
    n    = nbytes(typ);
    last = (n == 0) ? 1 : (we ? n + 1 : n + 2);
    rd   = 'x;
    er   = 'x;
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_type  = typ;
    @(posedge clk);  // cycle 0: accept
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("mem_en", {31'b0, mem_en}, 32'(c <= n));
      if (c <= n) begin
        check("mem_addr", 32'(mem_addr), 32'((int'(addr) + c - 1) % DEPTH));
        check("mem_we", {31'b0, mem_we}, {31'b0, we});
        check("mem_wdata", 32'(mem_wdata), we ? ((wd >> (8 * (c - 1))) & 32'hFF) : 32'h0);
      end
      check("resp_valid", {31'b0, resp_valid}, 32'(c == last));
      check("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (resp_valid) begin
        rd = resp_rdata;
        er = resp_err;
      end
    end
    @(negedge clk);
    check("resp_pulse_end", {31'b0, resp_valid}, 32'd0);
    check("ready_after", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    typ;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          snap, mism;

    vecs[0]  = '{1'b1, 6'd4,  32'h80817F01, 3'b000, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 6'd4,  32'h0,        3'b000, 32'h80817F01, 1'b0};
    vecs[2]  = '{1'b0, 6'd6,  32'h0,        3'b001, 32'hFFFF8081, 1'b0};
    vecs[3]  = '{1'b0, 6'd6,  32'h0,        3'b010, 32'h00008081, 1'b0};
    vecs[4]  = '{1'b0, 6'd7,  32'h0,        3'b011, 32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 6'd7,  32'h0,        3'b100, 32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 6'd5,  32'h0,        3'b011, 32'h0000007F, 1'b0};
    vecs[7]  = '{1'b1, 6'd62, 32'hDDCCBBAA, 3'b000, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 6'd62, 32'h0,        3'b000, 32'hDDCCBBAA, 1'b0};
    vecs[9]  = '{1'b0, 6'd10, 32'h0,        3'b101, 32'h00000000, 1'b1};
    vecs[10] = '{1'b1, 6'd30, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1};
    vecs[11] = '{1'b1, 6'd63, 32'h0000BEEF, 3'b001, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 6'd63, 32'h0,        3'b010, 32'h0000BEEF, 1'b0};
    vecs[13] = '{1'b0, 6'd62, 32'h0,        3'b000, 32'hDDBEEFAA, 1'b0};
    vecs[14] = '{1'b0, 6'd0,  32'h0,        3'b001, 32'hFFFFDDBE, 1'b0};
    vecs[15] = '{1'b1, 6'd40, 32'h12345678, 3'b011, 32'h00000000, 1'b0};
    vecs[16] = '{1'b0, 6'd40, 32'h0,        3'b100, 32'h00000078, 1'b0};

    for (int i = 0; i < DEPTH; i++) shadow[i] = init_byte(i);

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_type = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    check("rst_req_ready",  {31'b0, req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, resp_err},   32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_mem_en",     {31'b0, mem_en},     32'd0);
    check("rst_mem_we",     {31'b0, mem_we},     32'd0);
    check("rst_mem_addr",   32'(mem_addr),       32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),      32'd0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].typ, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      if (vecs[i].we) apply_store(vecs[i].addr, vecs[i].wdata, vecs[i].typ);
    end

    // Reset in the middle of a word store, after two bytes are written
    snap = resp_count;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd20;
    req_wdata = 32'h11223344; req_type = 3'b000;
    @(posedge clk);            // accept
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);            // byte 0 written
    @(posedge clk);            // byte 1 written
    #1 rst = 1'b1;
    #1;
    check("abort_mem_en", {31'b0, mem_en}, 32'd0);
    check("abort_mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_no_resp", 32'(resp_count), 32'(snap));
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_b20", 32'(mem[20]), 32'h44);
    check("abort_b21", 32'(mem[21]), 32'h33);
    check("abort_b22", 32'(mem[22]), 32'(init_byte(22)));
    check("abort_b23", 32'(mem[23]), 32'(init_byte(23)));
    shadow[20] = 8'h44;
    shadow[21] = 8'h33;
    do_req(1'b0, 6'd20, 32'h0, 3'b000, rd, er);
    check("abort_reload", rd, {init_byte(23), init_byte(22), 8'h33, 8'h44});
    check("abort_reload_err", {31'b0, er}, 32'd0);

    // Randomized requests against the reference model
    for (int k = 0; k < 60; k++) begin
      logic          we;
      logic [AW-1:0] a;
      logic [31:0]   wd, exp;
      logic [2:0]    t;
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      t  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      exp = (we || nbytes(t) == 0) ? 32'h0 : model_load(a, t);
      do_req(we, a, wd, t, rd, er);
      check("rand_rdata", rd, exp);
      check("rand_err", {31'b0, er}, 32'(nbytes(t) == 0));
      if (we) apply_store(a, wd, t);
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== shadow[i]) mism++;
    check("mem_image", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
